mem_cmd_ctrl: RTL and testbench

Byte-stream command controller sitting directly upstream of the 10-entry byte scratch memory in the Tiny Tapeout user design. It accepts command bytes over a valid/ready input, decodes single write, single read and auto-incrementing fill commands, and drives the memory's write and read ports. Read data is returned over a valid/ready output stream. Addresses wrap at DEPTH. Out-of-range accesses are dropped and flagged on a sticky error output.

---
 rtl/mem_cmd_ctrl_if.sv | 25 ++
 rtl/mem_cmd_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_cmd_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_ctrl_if.sv
// Byte-stream command, memory port and read-return signals of mem_cmd_ctrl.
// The controller takes the slave side; the upstream/memory environment takes the master side.
interface mem_cmd_ctrl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    modport slave (
        input  in_data, in_valid, mem_rdata, out_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, out_data, out_valid, err
    );

    modport master (
        output in_data, in_valid, mem_rdata, out_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, out_data, out_valid, err
    );
endinterface

// File: rtl/mem_cmd_ctrl.sv
// Command controller in front of a DEPTH-entry byte memory: decodes WRITE/READ/FILL
// opcodes from a valid/ready byte stream and returns read data on a valid/ready stream.
module mem_cmd_ctrl #(
    parameter int DEPTH = 10
) (
    input logic          clk,
    input logic          rst_n,
    mem_cmd_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WDATA  = 3'd1;
    localparam logic [2:0] S_FCOUNT = 3'd2;
    localparam logic [2:0] S_FDATA  = 3'd3;
    localparam logic [2:0] S_RADDR  = 3'd4;
    localparam logic [2:0] S_RWAIT  = 3'd5;
    localparam logic [2:0] S_RSEND  = 3'd6;

    localparam logic [4:0] DEPTH_W   = 5'(DEPTH);
    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    logic [2:0] state;
    logic [3:0] cur_addr;
    logic       bad;
    logic [7:0] remain;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       err;

    logic       accept;
    logic [1:0] op;
    logic [3:0] op_addr;
    logic       op_bad;

    assign op      = bus.in_data[7:6];
    assign op_addr = bus.in_data[3:0];
    assign op_bad  = {1'b0, op_addr} >= DEPTH_W;

    // NOTE: in_ready depends only on the state register; rst_n gating keeps it low during reset.
    assign bus.in_ready = rst_n && (state == S_IDLE || state == S_WDATA ||
                                    state == S_FCOUNT || state == S_FDATA);
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.err       = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            bad       <= 1'b0;
            remain    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: default-low each cycle makes mem_we a single-cycle strobe per write.
            mem_we <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    cur_addr <= op_addr;
                    bad      <= op_bad;
                    case (op)
                        2'b00: if (bus.in_data[5]) err <= 1'b0;
                        2'b01: begin
                            if (op_bad) err <= 1'b1;
                            state <= S_WDATA;
                        end
                        2'b10: begin
                            if (op_bad) err <= 1'b1;
                            else        mem_addr <= op_addr;
                            state <= S_RADDR;
                        end
                        default: begin
                            if (op_bad) err <= 1'b1;
                            state <= S_FCOUNT;
                        end
                    endcase
                end
                S_WDATA: if (accept) begin
                    if (!bad) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_wdata <= bus.in_data;
                    end
                    state <= S_IDLE;
                end
                S_FCOUNT: if (accept) begin
                    remain <= bus.in_data;
                    state  <= (bus.in_data == 8'd0) ? S_IDLE : S_FDATA;
                end
                // Bad fills still count down so the stream stays framed.
                S_FDATA: if (accept) begin
                    if (!bad) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_wdata <= bus.in_data;
                    end
                    cur_addr <= (cur_addr == LAST_ADDR) ? 4'd0 : cur_addr + 4'd1;
                    remain   <= remain - 8'd1;
                    if (remain == 8'd1) state <= S_IDLE;
                end
                S_RADDR: state <= S_RWAIT;
                S_RWAIT: begin
                    if (bad) begin
                        state <= S_IDLE;
                    end else begin
                        out_data  <= bus.mem_rdata;
                        out_valid <= 1'b1;
                        state     <= S_RSEND;
                    end
                end
                S_RSEND: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Self-checking bench for mem_cmd_ctrl: directed scenarios followed by random command
// traffic, all checked against a command-level reference model of the memory and err flag.
module tb_mem_cmd_ctrl;
    localparam int DEPTH = 10;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_cmd_ctrl_if bus ();

    mem_cmd_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory with synchronous read, driven by the DUT.
    logic [7:0] env_mem [16];
    always @(posedge clk) begin
        if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= env_mem[bus.mem_addr];
    end

    wr_t got_q[$];
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) got_q.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
    end

    // Reference model state
    logic [7:0] ref_mem [16];
    logic       ref_err;
    wr_t        exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(negedge clk);
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b, output int acc);
        idle($urandom_range(0, 2));
        send_byte(b, acc);
    endtask

    task automatic model_write(input logic [3:0] a, input logic [7:0] d, input int c);
        if (int'(a) < DEPTH) begin
            ref_mem[a] = d;
            exp_q.push_back('{c, a, d});
        end else begin
            ref_err = 1'b1;
        end
    endtask

    task automatic cmp_writes(input string tag);
        @(negedge clk);
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_wr_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_wr_data"}, got_q[i].data, exp_q[i].data);
            if (exp_q[i].cyc >= 0) check({tag, "_wr_cycle"}, got_q[i].cyc, exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_err"}, bus.err, ref_err);
    endtask

    task automatic do_read(input logic [3:0] a, input int hold);
        int acc, n;
        logic [7:0] held;
        bit busy_bad, seen;
        send_byte({4'b1000, a}, acc);
        if (int'(a) < DEPTH) begin
            n = 0;
            busy_bad = 1'b0;
            while (!bus.out_valid && n < 10) begin
                if (bus.in_ready) busy_bad = 1'b1;
                @(negedge clk);
                n++;
            end
            check("rd_valid", bus.out_valid, 1);
            check("rd_latency", cyc - acc, 2);
            check("rd_data", bus.out_data, ref_mem[a]);
            held = bus.out_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!bus.out_valid || bus.out_data !== held || bus.in_ready) busy_bad = 1'b1;
            end
            check("rd_hold", busy_bad, 0);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("rd_done_valid", bus.out_valid, 0);
            check("rd_done_ready", bus.in_ready, 1);
        end else begin
            ref_err = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                seen |= bus.out_valid;
            end
            check("bad_rd_novalid", seen, 0);
            check("bad_rd_ready", bus.in_ready, 1);
        end
        check("rd_err", bus.err, ref_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc_list[4];
        logic [7:0] v;
        logic [3:0] a;
        int ptr, n, kind;
        logic [7:0] d;

        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        ref_err       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            env_mem[i] <= v;
            ref_mem[i] = v;
        end

        // Reset state
        #2;
        check_reset_outputs("reset");
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", bus.in_ready, 1);

        // WRITE 3 <- 0xA5
        send_byte(8'h43, acc);
        send_byte(8'hA5, acc);
        model_write(4'd3, 8'hA5, acc);
        cmp_writes("write");

        // READ with 5 cycles of backpressure
        env_mem[3] <= 8'h5C;
        ref_mem[3] = 8'h5C;
        @(negedge clk);
        do_read(4'd3, 5);

        // FILL with wrap at DEPTH, back-to-back data
        send_byte(8'hC8, acc);
        send_byte(8'h04, acc);
        send_byte(8'h11, acc_list[0]);
        send_byte(8'h22, acc_list[1]);
        send_byte(8'h33, acc_list[2]);
        send_byte(8'h44, acc_list[3]);
        model_write(4'd8, 8'h11, acc_list[0]);
        model_write(4'd9, 8'h22, acc_list[1]);
        model_write(4'd0, 8'h33, acc_list[2]);
        model_write(4'd1, 8'h44, acc_list[3]);
        check("fill_full_rate", acc_list[3] - acc_list[0], 3);
        cmp_writes("fill_wrap");

        // Bad address: dropped write, bad read, then clear
        send_byte(8'h4C, acc);
        send_byte(8'h77, acc);
        model_write(4'hC, 8'h77, acc);
        cmp_writes("bad_write");
        do_read(4'hF, 0);
        send_byte(8'h20, acc);
        ref_err = 1'b0;
        cmp_writes("err_clear");

        // FILL N=0, then a write with in_valid gaps
        send_byte(8'hC2, acc);
        send_byte(8'h00, acc);
        idle(3);
        send_byte(8'h42, acc);
        idle(3);
        send_byte(8'h99, acc);
        model_write(4'd2, 8'h99, acc);
        cmp_writes("fill_n0_gaps");

        // Reset in the middle of a fill
        send_byte(8'hC0, acc);
        send_byte(8'h04, acc);
        send_byte(8'hAA, acc);
        model_write(4'd0, 8'hAA, acc);
        send_byte(8'hBB, acc);
        model_write(4'd1, 8'hBB, acc);
        cmp_writes("pre_reset_fill");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_fill_reset");
        idle(2);
        rst_n = 1'b1;
        got_q.delete();
        ref_err = 1'b0;
        @(negedge clk);
        check("post_reset2_in_ready", bus.in_ready, 1);
        do_read(4'd1, 1);

        // Random command traffic
        for (int it = 0; it < 150; it++) begin
            kind = int'($urandom_range(0, 3));
            a = 4'($urandom_range(0, 15));
            case (kind)
                0: begin
                    v = {2'b00, 1'($urandom), 1'($urandom), 4'd0};
                    send_gap(v, acc);
                    if (v[5]) ref_err = 1'b0;
                    cmp_writes("rnd_nop");
                end
                1: begin
                    d = 8'($urandom);
                    send_gap({2'b01, 2'($urandom), a}, acc);
                    send_gap(d, acc);
                    model_write(a, d, -1);
                    cmp_writes("rnd_write");
                end
                2: begin
                    do_read(a, int'($urandom_range(0, 3)));
                end
                default: begin
                    n = int'($urandom_range(0, 5));
                    send_gap({2'b11, 2'($urandom), a}, acc);
                    send_gap(8'(n), acc);
                    if (int'(a) >= DEPTH) ref_err = 1'b1;
                    ptr = int'(a);
                    for (int i = 0; i < n; i++) begin
                        d = 8'($urandom);
                        send_gap(d, acc);
                        if (int'(a) < DEPTH) begin
                            model_write(4'(ptr), d, -1);
                            ptr = (ptr + 1) % DEPTH;
                        end
                    end
                    cmp_writes("rnd_fill");
                end
            endcase
        end

        // Final sweep: every legal address reads back the modelled contents
        for (int i = 0; i < DEPTH; i++) do_read(4'(i), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
